// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for the multi-cycle core. It holds the program
// counter and the instruction register, and runs a req/ack handshake to the
// instruction memory. It also forms absolute and relative branch targets from
// the instruction currently held in IR. The control FSM decodes the OPCODE
// and MM fields.
//
// Parameters
//   PC_W     program counter / instruction address width (must be <= 32,
//            because branch targets are taken from IR[PC_W-1:0])
//   TIMEOUT  wait cycles allowed for IM_ACK before the fetch is abandoned;
//            0 disables the timeout
//
// Ports
//   CLK          system clock, rising edge
//   RST_F        asynchronous active-low reset, clears everything
//   PC_WRITE     fetch request from the control FSM
//   PC_SEL       1 = next fetch goes to the branch target, 0 = to PC
//   BR_SEL       1 = absolute target, 0 = CUR_PC-relative target
//   PC_RST       synchronous clear of PC/IR/fetch state (sticky flags kept)
//   IM_REQ       instruction memory request, registered
//   IM_ADDR      instruction memory address, registered
//   IM_ACK       memory data valid
//   IM_RDATA     instruction word from memory
//   IR           instruction register
//   OPCODE       IR[31:28]
//   MM           IR[27:24]
//   CUR_PC       address of the instruction held in IR
//   INSTR_VALID  one-cycle pulse whenever IR is written (fetch or timeout)
//   FETCH_BUSY   high while a request is outstanding
//   FETCH_TO     sticky: a fetch was abandoned for lack of an ack
//   OVERRUN      sticky: PC_WRITE arrived while a fetch was outstanding
// ---------------------------------------------------------------------------
module fetch_unit #(
   parameter int PC_W    = 16,
   parameter int TIMEOUT = 8
) (
   input  logic            CLK,
   input  logic            RST_F,
   input  logic            PC_WRITE,
   input  logic            PC_SEL,
   input  logic            BR_SEL,
   input  logic            PC_RST,
   output logic            IM_REQ,
   output logic [PC_W-1:0] IM_ADDR,
   input  logic            IM_ACK,
   input  logic [31:0]     IM_RDATA,
   output logic [31:0]     IR,
   output logic [3:0]      OPCODE,
   output logic [3:0]      MM,
   output logic [PC_W-1:0] CUR_PC,
   output logic            INSTR_VALID,
   output logic            FETCH_BUSY,
   output logic            FETCH_TO,
   output logic            OVERRUN
);

   // Wide enough to hold the value TIMEOUT itself.
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Registered state and its next-state values
   // ------------------------------------------------------------------
   state_t            state,       state_d;
   logic [PC_W-1:0]   pc,          pc_d;
   logic [PC_W-1:0]   cur_pc,      cur_pc_d;
   logic [31:0]       ir,          ir_d;
   logic              im_req,      im_req_d;
   logic [PC_W-1:0]   im_addr,     im_addr_d;
   logic              instr_valid, instr_valid_d;
   logic              fetch_to,    fetch_to_d;
   logic              overrun,     overrun_d;
   logic [CNT_W-1:0]  wait_cnt,    wait_cnt_d;

   // Helper terms
   logic [PC_W-1:0]   br_field;
   logic [PC_W-1:0]   fetch_addr;
   logic [CNT_W-1:0]  wait_inc;
   logic              timeout_hit;

   assign br_field = ir[PC_W-1:0];

   // ------------------------------------------------------------------
   // Fetch address selection. This only matters at the IDLE edge that
   // accepts PC_WRITE, so PC_SEL and BR_SEL are effectively sampled there.
   // The offset is already PC_W bits wide, so sign-extending it to PC_W
   // changes nothing. A plain PC_W-bit add then gives the two's-complement
   // relative target modulo 2^PC_W.
   // ------------------------------------------------------------------
   always_comb begin
      fetch_addr = pc;
      if (PC_SEL) begin
         if (BR_SEL) fetch_addr = br_field;
         else        fetch_addr = cur_pc + br_field;
      end
   end

   // The counter holds the number of ack-less REQ edges seen so far. The
   // timeout fires on the edge where that count would reach TIMEOUT.
   assign wait_inc    = wait_cnt + CNT_W'(1);
   assign timeout_hit = (TIMEOUT > 0) && (wait_inc == CNT_W'(TIMEOUT));

   // ------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable written here first gets its hold value, so no
      // path through the branches below leaves one unassigned (no latches).
      state_d       = state;
      pc_d          = pc;
      cur_pc_d      = cur_pc;
      ir_d          = ir;
      im_req_d      = im_req;
      im_addr_d     = im_addr;
      instr_valid_d = 1'b0;
      fetch_to_d    = fetch_to;
      overrun_d     = overrun;
      wait_cnt_d    = wait_cnt;

      if (PC_RST) begin
         // Synchronous clear. It wins over PC_WRITE and aborts any
         // outstanding request. The sticky error flags survive it.
         state_d    = IDLE;
         pc_d       = '0;
         cur_pc_d   = '0;
         ir_d       = '0;
         im_req_d   = 1'b0;
         im_addr_d  = '0;
         wait_cnt_d = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (PC_WRITE) begin
                  im_addr_d  = fetch_addr;
                  im_req_d   = 1'b1;
                  wait_cnt_d = '0;
                  state_d    = REQ;
               end
            end

            REQ: begin
               // The request is still in flight, so a new fetch request
               // cannot be honoured. It is only recorded.
               if (PC_WRITE) overrun_d = 1'b1;

               if (IM_ACK) begin
                  // An ack beats a timeout that lands on the same edge.
                  ir_d          = IM_RDATA;
                  cur_pc_d      = im_addr;
                  pc_d          = im_addr + PC_W'(1);
                  instr_valid_d = 1'b1;
                  im_req_d      = 1'b0;
                  state_d       = IDLE;
               end else if (timeout_hit) begin
                  // Abandon the fetch and hand the FSM a noop. PC and
                  // CUR_PC stay put, so a sequential refetch retries the
                  // same address.
                  ir_d          = '0;
                  fetch_to_d    = 1'b1;
                  instr_valid_d = 1'b1;
                  im_req_d      = 1'b0;
                  state_d       = IDLE;
               end else if (TIMEOUT > 0) begin
                  wait_cnt_d = wait_inc;
               end
            end

            default: state_d = IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_F) begin
      if (!RST_F) begin
         state       <= IDLE;
         pc          <= '0;
         cur_pc      <= '0;
         ir          <= '0;
         im_req      <= 1'b0;
         im_addr     <= '0;
         instr_valid <= 1'b0;
         fetch_to    <= 1'b0;
         overrun     <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register updates from
         // the values present before this edge, regardless of order.
         state       <= state_d;
         pc          <= pc_d;
         cur_pc      <= cur_pc_d;
         ir          <= ir_d;
         im_req      <= im_req_d;
         im_addr     <= im_addr_d;
         instr_valid <= instr_valid_d;
         fetch_to    <= fetch_to_d;
         overrun     <= overrun_d;
         wait_cnt    <= wait_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs. All of them come straight from registers, apart from the
   // IR field slices and the state decode.
   // ------------------------------------------------------------------
   assign IM_REQ      = im_req;
   assign IM_ADDR     = im_addr;
   assign IR          = ir;
   assign OPCODE      = ir[31:28];
   assign MM          = ir[27:24];
   assign CUR_PC      = cur_pc;
   assign INSTR_VALID = instr_valid;
   assign FETCH_BUSY  = (state == REQ);
   assign FETCH_TO    = fetch_to;
   assign OVERRUN     = overrun;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Bench for fetch_unit. The stimulus side plays both the control FSM and an
// instruction memory with a chosen ack delay. The reference model tracks the
// architectural PC / CUR_PC / IR and the sticky flags. For each fetch the
// bench predicts the address and the completion (data or timeout noop), and
// pushes the expected result into a queue. A separate monitor pops one entry
// each time INSTR_VALID is seen.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int PC_W    = 16;
   localparam int TIMEOUT = 8;

   logic            CLK = 1'b0;
   logic            RST_F;
   logic            PC_WRITE, PC_SEL, BR_SEL, PC_RST;
   logic            IM_REQ;
   logic [PC_W-1:0] IM_ADDR;
   logic            IM_ACK;
   logic [31:0]     IM_RDATA;
   logic [31:0]     IR;
   logic [3:0]      OPCODE, MM;
   logic [PC_W-1:0] CUR_PC;
   logic            INSTR_VALID, FETCH_BUSY, FETCH_TO, OVERRUN;

   fetch_unit #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .RST_F(RST_F), .PC_WRITE(PC_WRITE), .PC_SEL(PC_SEL),
      .BR_SEL(BR_SEL), .PC_RST(PC_RST), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR),
      .IM_ACK(IM_ACK), .IM_RDATA(IM_RDATA), .IR(IR), .OPCODE(OPCODE), .MM(MM),
      .CUR_PC(CUR_PC), .INSTR_VALID(INSTR_VALID), .FETCH_BUSY(FETCH_BUSY),
      .FETCH_TO(FETCH_TO), .OVERRUN(OVERRUN)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: architectural state only
   // ------------------------------------------------------------------
   logic [15:0] m_pc, m_cur_pc;
   logic [31:0] m_ir;
   logic        m_to, m_ovr;

   typedef struct {
      logic [31:0] ir;
      logic [15:0] cur_pc;
      logic        to;
      logic        ovr;
   } exp_t;

   exp_t exp_q[$];

   function automatic void model_clear(input bit keep_sticky);
      m_pc = '0; m_cur_pc = '0; m_ir = '0;
      if (!keep_sticky) begin m_to = 1'b0; m_ovr = 1'b0; end
   endfunction

   // ------------------------------------------------------------------
   // Monitor: one scoreboard entry per INSTR_VALID pulse
   // ------------------------------------------------------------------
   always @(negedge CLK) begin
      if (RST_F === 1'b1 && INSTR_VALID === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_instr_valid", 1, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("ir",        IR,         e.ir);
            check("opcode",    OPCODE,     e.ir[31:28]);
            check("mm",        MM,         e.ir[27:24]);
            check("cur_pc",    CUR_PC,     e.cur_pc);
            check("fetch_to",  FETCH_TO,   e.to);
            check("overrun",   OVERRUN,    e.ovr);
            check("idle_on_valid", FETCH_BUSY, 0);
         end
      end
   end

   // ------------------------------------------------------------------
   // One fetch transaction. d = number of ack-less REQ cycles before the
   // memory answers. If d >= TIMEOUT the ack comes too late and must be
   // ignored. poke = pulse PC_WRITE during the first REQ cycle.
   // ------------------------------------------------------------------
   task automatic fetch(input bit sel, input bit br, input int d,
                        input logic [31:0] data, input bit poke);
      logic [15:0] fa;
      int          n_req, req_cnt;
      bit          timed_out;
      exp_t        e;

      if (!sel)     fa = m_pc;
      else if (br)  fa = m_ir[15:0];
      else          fa = 16'(int'(m_cur_pc) + int'($signed(m_ir[15:0])));

      timed_out = (d >= TIMEOUT);
      n_req     = timed_out ? TIMEOUT : d + 1;
      if (poke) m_ovr = 1'b1;
      if (timed_out) begin
         m_ir = '0;
         m_to = 1'b1;
      end else begin
         m_ir     = data;
         m_cur_pc = fa;
         m_pc     = 16'(fa + 16'd1);
      end
      e.ir = m_ir; e.cur_pc = m_cur_pc; e.to = m_to; e.ovr = m_ovr;
      exp_q.push_back(e);

      @(posedge CLK); #1;
      PC_SEL = sel; BR_SEL = br; PC_WRITE = 1'b1;
      @(posedge CLK); #1;
      PC_WRITE = 1'b0;
      PC_SEL = 1'($urandom); BR_SEL = 1'($urandom);
      check("req_asserted", IM_REQ, 1);
      check("fetch_addr",   IM_ADDR, fa);
      check("busy_on_req",  FETCH_BUSY, 1);
      req_cnt = 1;
      for (int k = 1; k <= d + 1; k++) begin
         IM_ACK   = (k == d + 1);
         IM_RDATA = (k == d + 1) ? data : $urandom;
         PC_WRITE = poke && (k == 1);
         @(posedge CLK); #1;
         IM_ACK = 1'b0; PC_WRITE = 1'b0;
         if (IM_REQ === 1'b1) begin
            req_cnt++;
            check("addr_stable", IM_ADDR, fa);
         end
         check("busy_tracks_req", FETCH_BUSY, IM_REQ);
      end
      check("req_cycles", req_cnt, n_req);
      check("req_dropped", IM_REQ, 0);
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      RST_F = 1'b0; PC_WRITE = 1'b0; PC_SEL = 1'b0; BR_SEL = 1'b0;
      PC_RST = 1'b0; IM_ACK = 1'b0; IM_RDATA = '0;
      model_clear(0);
      repeat (3) @(posedge CLK);
      #1;
      check("rst_im_req",  IM_REQ, 0);
      check("rst_im_addr", IM_ADDR, 0);
      check("rst_ir",      IR, 0);
      check("rst_cur_pc",  CUR_PC, 0);
      check("rst_valid",   INSTR_VALID, 0);
      check("rst_busy",    FETCH_BUSY, 0);
      check("rst_to",      FETCH_TO, 0);
      check("rst_ovr",     OVERRUN, 0);
      @(negedge CLK); RST_F = 1'b1;

      // Sequential fetches: zero-wait, then 3 wait states with an overrun poke
      fetch(0, 0, 0, 32'h8012_0003, 0);
      check("first_opcode", OPCODE, 4'h8);
      fetch(0, 0, 3, 32'h4000_0005, 1);
      // Absolute jump to 5, which holds 0x40000020. Then jump to 0x20 and run on.
      fetch(1, 1, 0, 32'h4000_0020, 0);
      fetch(1, 1, 1, 32'h4000_0010, 0);        // fetched from 0x0020
      fetch(0, 0, 0, 32'h4000_0010, 0);        // fetched from 0x0021
      // Relative: CUR_PC=0x10 with IR=0x5000FFFE gives 0x000E
      fetch(1, 1, 0, 32'h5000_FFFE, 0);        // at 0x0010
      fetch(1, 0, 2, 32'h4000_0001, 0);        // at 0x000E
      fetch(1, 1, 0, 32'h5000_FFFE, 0);        // at 0x0001
      fetch(1, 0, 0, $urandom, 0);             // at 0xFFFF (wrap)
      fetch(0, 0, 0, $urandom, 0);             // PC wraps to 0x0000
      // Ack on the last permitted cycle completes normally
      fetch(0, 0, TIMEOUT - 1, 32'h1234_5678, 0);
      check("no_timeout_on_last_cycle", FETCH_TO, 0);
      // Timeout, then a retry of the same address. The first ack arrives late.
      fetch(0, 0, TIMEOUT + 1, 32'hDEAD_BEEF, 0);
      fetch(0, 0, 1, 32'h3300_0000, 0);

      // PC_RST mid-fetch, then a late ack that must be ignored
      @(posedge CLK); #1; PC_SEL = 1'b0; PC_WRITE = 1'b1;
      @(posedge CLK); #1; PC_WRITE = 1'b0;
      check("pcrst_req_up", IM_REQ, 1);
      @(posedge CLK); #1; PC_RST = 1'b1;
      @(posedge CLK); #1; PC_RST = 1'b0;
      model_clear(1);
      check("pcrst_req",   IM_REQ, 0);
      check("pcrst_busy",  FETCH_BUSY, 0);
      check("pcrst_ir",    IR, 0);
      check("pcrst_curpc", CUR_PC, 0);
      check("pcrst_addr",  IM_ADDR, 0);
      check("pcrst_to",    FETCH_TO, m_to);
      check("pcrst_ovr",   OVERRUN, m_ovr);
      IM_ACK = 1'b1; IM_RDATA = 32'hFFFF_FFFF;
      @(posedge CLK); #1; IM_ACK = 1'b0;
      check("late_ack_ir", IR, 0);
      check("late_ack_req", IM_REQ, 0);
      fetch(0, 0, 0, 32'h9000_0100, 0);        // from address 0 again

      // Randomized traffic
      for (int i = 0; i < 60; i++)
         fetch(1'($urandom), 1'($urandom), $urandom_range(0, TIMEOUT + 2),
               $urandom, ($urandom_range(0, 7) == 0));

      // Asynchronous reset in the middle of a fetch
      @(posedge CLK); #1; PC_SEL = 1'b0; PC_WRITE = 1'b1;
      @(posedge CLK); #1; PC_WRITE = 1'b0;
      check("arst_req_up", IM_REQ, 1);
      #2 RST_F = 1'b0;
      #1;
      model_clear(0);
      check("arst_req",   IM_REQ, 0);
      check("arst_addr",  IM_ADDR, 0);
      check("arst_ir",    IR, 0);
      check("arst_curpc", CUR_PC, 0);
      check("arst_valid", INSTR_VALID, 0);
      check("arst_busy",  FETCH_BUSY, 0);
      check("arst_to",    FETCH_TO, 0);
      check("arst_ovr",   OVERRUN, 0);
      @(negedge CLK); RST_F = 1'b1;

      for (int i = 0; i < 10; i++)
         fetch(1'($urandom), 1'($urandom), $urandom_range(0, TIMEOUT + 2),
               $urandom, ($urandom_range(0, 7) == 0));

      repeat (3) @(posedge CLK);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
